// File: rtl/conv_fc_pkg.sv
// Shared constants, width helpers and tile-index type for the conv -> FC pipeline.
package conv_fc_pkg;

    localparam int IN_W_D    = 8;
    localparam int N_TAPS_D  = 9;
    localparam int N_POS_D   = 26;
    localparam int N_TILES_D = 26;
    localparam int N_CLS_D   = 10;
    localparam int ACC_W_D   = 32;

    localparam int TILE_W_D  = $clog2(N_TILES_D);
    typedef logic [TILE_W_D-1:0] tile_t;

    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Full-precision width of one conv output: product plus tap growth plus bias headroom.
    function automatic int conv_w(input int in_w, input int n_taps);
        return 2 * in_w + $clog2(n_taps) + 1;
    endfunction

endpackage

// File: rtl/fc_mac_row.sv
// One FC class: dot product of a conv beat with its weight row, bias-initialised accumulate.
module fc_mac_row import conv_fc_pkg::*; #(
    parameter int IN_W  = IN_W_D,
    parameter int N_POS = N_POS_D,
    parameter int CW    = conv_w(IN_W_D, N_TAPS_D),
    parameter int ACC_W = ACC_W_D
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_take,
    input  logic                    i_first,
    input  logic signed [CW-1:0]    i_conv   [N_POS],
    input  logic signed [IN_W-1:0]  i_weight [N_POS],
    input  logic signed [IN_W-1:0]  i_bias,
    output logic signed [ACC_W-1:0] o_acc_nxt
);

    localparam int PW = prod_w(CW, IN_W);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] dot;

    // Sum wraps modulo 2^ACC_W; products wider than ACC_W are truncated the same way.
    always_comb begin
        dot = '0;
        for (int p = 0; p < N_POS; p++) begin
            dot = dot + ACC_W'(PW'(i_conv[p]) * PW'(i_weight[p]));
        end
    end

    assign o_acc_nxt = (i_first ? ACC_W'(i_bias) : acc) + dot;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc <= '0;
        end else if (i_take) begin
            acc <= o_acc_nxt;
        end
    end

endmodule

// File: rtl/conv_fc_pipe.sv
// Two-stage conv -> fully-connected pipeline, one beat (N_POS conv outputs) per cycle.
// Optional macro CONV_FC_RELU_EN clamps stage-1 conv results at zero.
module conv_fc_pipe import conv_fc_pkg::*; #(
    parameter int IN_W    = IN_W_D,
    parameter int N_TAPS  = N_TAPS_D,
    parameter int N_POS   = N_POS_D,
    parameter int N_TILES = N_TILES_D,
    parameter int N_CLS   = N_CLS_D,
    parameter int ACC_W   = ACC_W_D,
    localparam int TW     = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_pre_valid,
    output logic                    o_pre_ready,
    input  logic signed [IN_W-1:0]  i_patch       [N_POS][N_TAPS],
    input  logic signed [IN_W-1:0]  i_conv_kernel [N_TAPS],
    input  logic signed [IN_W-1:0]  i_conv_bias,
    output logic [TW-1:0]           o_wt_addr,
    input  logic signed [IN_W-1:0]  i_fc_weight   [N_CLS][N_POS],
    input  logic signed [IN_W-1:0]  i_fc_bias     [N_CLS],
    output logic                    o_post_valid,
    input  logic                    i_post_ready,
    output logic signed [ACC_W-1:0] o_res         [N_CLS]
);

    localparam int CW = conv_w(IN_W, N_TAPS);
    localparam int PW = prod_w(IN_W, IN_W);
    localparam logic [TW-1:0] LAST_TILE = TW'(N_TILES - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and a presented result holds o_res stable until it fires.
    logic                    conv_vld;
    logic signed [CW-1:0]    conv_q [N_POS];
    logic signed [CW-1:0]    conv_d [N_POS];
    logic [TW-1:0]           tile;
    logic                    s2_last;
    logic                    s2_take;
    logic signed [ACC_W-1:0] acc_nxt [N_CLS];

    assign s2_last     = (tile == LAST_TILE);
    assign s2_take     = conv_vld && !(s2_last && o_post_valid && !i_post_ready);
    assign o_pre_ready = !conv_vld || s2_take;
    assign o_wt_addr   = tile;

    always_comb begin
        for (int p = 0; p < N_POS; p++) begin
            conv_d[p] = CW'(i_conv_bias);
            for (int t = 0; t < N_TAPS; t++) begin
                conv_d[p] = conv_d[p] + CW'(PW'(i_patch[p][t]) * PW'(i_conv_kernel[t]));
            end
`ifdef CONV_FC_RELU_EN
            if (conv_d[p][CW-1]) begin
                conv_d[p] = '0;
            end
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            conv_vld <= 1'b0;
            for (int p = 0; p < N_POS; p++) begin
                conv_q[p] <= '0;
            end
        end else if (o_pre_ready) begin
            conv_vld <= i_pre_valid;
            if (i_pre_valid) begin
                conv_q <= conv_d;
            end
        end
    end

    for (genvar k = 0; k < N_CLS; k++) begin : g_row
        fc_mac_row #(
            .IN_W  (IN_W),
            .N_POS (N_POS),
            .CW    (CW),
            .ACC_W (ACC_W)
        ) u_row (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_take    (s2_take),
            .i_first   (tile == '0),
            .i_conv    (conv_q),
            .i_weight  (i_fc_weight[k]),
            .i_bias    (i_fc_bias[k]),
            .o_acc_nxt (acc_nxt[k])
        );
    end

    // A final tile taken in the same cycle as post-fire reloads o_res with no bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tile         <= '0;
            o_post_valid <= 1'b0;
            for (int k = 0; k < N_CLS; k++) begin
                o_res[k] <= '0;
            end
        end else begin
            if (s2_take) begin
                tile <= s2_last ? '0 : tile + 1'b1;
            end
            if (s2_take && s2_last) begin
                o_post_valid <= 1'b1;
                o_res        <= acc_nxt;
            end else if (i_post_ready) begin
                o_post_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_fc_pipe.sv
// Directed bench for conv_fc_pipe: expected class scores queued per frame, popped on post-fire.
module tb_conv_fc_pipe;

    localparam int IN_W    = 8;
    localparam int N_TAPS  = 9;
    localparam int N_POS   = 26;
    localparam int N_TILES = 26;
    localparam int N_CLS   = 10;
    localparam int ACC_W   = 32;
    localparam int TW      = $clog2(N_TILES);
    localparam int EW      = N_CLS * ACC_W;

    logic                    i_clk;
    logic                    i_rst;
    logic                    i_pre_valid;
    logic                    o_pre_ready;
    logic signed [IN_W-1:0]  i_patch       [N_POS][N_TAPS];
    logic signed [IN_W-1:0]  i_conv_kernel [N_TAPS];
    logic signed [IN_W-1:0]  i_conv_bias;
    logic [TW-1:0]           o_wt_addr;
    logic signed [IN_W-1:0]  i_fc_weight   [N_CLS][N_POS];
    logic signed [IN_W-1:0]  i_fc_bias     [N_CLS];
    logic                    o_post_valid;
    logic                    i_post_ready;
    logic signed [ACC_W-1:0] o_res         [N_CLS];

    logic [EW-1:0] exp_q[$];
    int            total;
    int            bad;
    int            cyc;
    int            stall_cnt;
    int            gaps_seen;
    int            last_fire;
    logic          gap_chk;
    logic          have_last;
    logic          addr_mode;

    conv_fc_pipe #(
        .IN_W    (IN_W),
        .N_TAPS  (N_TAPS),
        .N_POS   (N_POS),
        .N_TILES (N_TILES),
        .N_CLS   (N_CLS),
        .ACC_W   (ACC_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pre_valid   (i_pre_valid),
        .o_pre_ready   (o_pre_ready),
        .i_patch       (i_patch),
        .i_conv_kernel (i_conv_kernel),
        .i_conv_bias   (i_conv_bias),
        .o_wt_addr     (o_wt_addr),
        .i_fc_weight   (i_fc_weight),
        .i_fc_bias     (i_fc_bias),
        .o_post_valid  (o_post_valid),
        .i_post_ready  (i_post_ready),
        .o_res         (o_res)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Weight memory model: all ones, tile 3 doubled when addr_mode is set.
    always_comb begin
        for (int k = 0; k < N_CLS; k++) begin
            for (int p = 0; p < N_POS; p++) begin
                i_fc_weight[k][p] = (addr_mode && o_wt_addr == TW'(3)) ? IN_W'(2) : IN_W'(1);
            end
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic send_beat(input int pv, input int kv, input int cb);
        logic accepted;
        i_pre_valid = 1'b1;
        for (int p = 0; p < N_POS; p++) begin
            for (int t = 0; t < N_TAPS; t++) begin
                i_patch[p][t] = IN_W'(pv);
            end
        end
        for (int t = 0; t < N_TAPS; t++) begin
            i_conv_kernel[t] = IN_W'(kv);
        end
        i_conv_bias = IN_W'(cb);
        accepted = 1'b0;
        for (int c = 0; c < 500 && !accepted; c++) begin
            @(negedge i_clk);
            if (o_pre_ready) accepted = 1'b1;
            else stall_cnt++;
            @(posedge i_clk);
            #1;
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL beat_accept_timeout: got no ready expected ready within 500 cycles");
        end
    endtask

    task automatic send_frame(input int pv, input int kv, input int cb);
        for (int b = 0; b < N_TILES; b++) begin
            send_beat(pv, kv, cb);
        end
        i_pre_valid = 1'b0;
    endtask

    task automatic push_exp(input int base, input logic add_k);
        logic [EW-1:0] e;
        for (int k = 0; k < N_CLS; k++) begin
            e[k*ACC_W +: ACC_W] = ACC_W'(base + (add_k ? k : 0));
        end
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
            @(posedge i_clk);
        end
        #1;
        check(name, longint'(exp_q.size()), 0);
    endtask

    // scoreboard monitor: compare on every post-fire
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_post_valid && i_post_ready) begin
                if (gap_chk) begin
                    if (have_last) begin
                        gaps_seen++;
                        check("post_valid_gap", longint'(cyc - last_fire), N_TILES);
                    end
                    have_last = 1'b1;
                    last_fire = cyc;
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got o_res[0]=%0d expected no result", o_res[0]);
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < N_CLS; k++) begin
                        total++;
                        if (o_res[k] !== e[k*ACC_W +: ACC_W]) begin
                            bad++;
                            $display("FAIL o_res[%0d]: got %0d expected %0d", k, o_res[k],
                                     $signed(e[k*ACC_W +: ACC_W]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        total       = 0;
        bad         = 0;
        stall_cnt   = 0;
        gaps_seen   = 0;
        last_fire   = 0;
        gap_chk     = 1'b0;
        have_last   = 1'b0;
        addr_mode   = 1'b0;
        i_rst       = 1'b1;
        i_pre_valid = 1'b0;
        i_post_ready = 1'b1;
        i_conv_bias = '0;
        for (int p = 0; p < N_POS; p++) begin
            for (int t = 0; t < N_TAPS; t++) i_patch[p][t] = '0;
        end
        for (int t = 0; t < N_TAPS; t++) i_conv_kernel[t] = '0;
        for (int k = 0; k < N_CLS; k++) i_fc_bias[k] = IN_W'(5);

        repeat (3) @(posedge i_clk);
        #1;
        check("rst_post_valid", longint'(o_post_valid), 0);
        check("rst_pre_ready", longint'(o_pre_ready), 1);
        check("rst_wt_addr", longint'(o_wt_addr), 0);
        check("rst_res0", longint'(o_res[0]), 0);
        check("rst_res_last", longint'(o_res[N_CLS-1]), 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // all ones: 9*26*26 + 5
        push_exp(6089, 1'b0);
        send_frame(1, 1, 0);

        // negative kernel: -6084 + 5, or bias only when conv is clamped
`ifdef CONV_FC_RELU_EN
        push_exp(5, 1'b0);
`else
        push_exp(-6079, 1'b0);
`endif
        send_frame(1, -1, 0);

        // patch 2, kernel 3, conv bias -10: conv 44, 44*26*26 + 5
        push_exp(29749, 1'b0);
        send_frame(2, 3, -10);

        // tile 3 weights doubled, class bias k: 6084 + 234 + k
        for (int k = 0; k < N_CLS; k++) i_fc_bias[k] = IN_W'(k);
        addr_mode = 1'b1;
        push_exp(6318, 1'b1);
        send_frame(1, 1, 0);
        addr_mode = 1'b0;
        for (int k = 0; k < N_CLS; k++) i_fc_bias[k] = IN_W'(5);
        drain("drain_directed");

        // back-to-back frames with the sink always ready
        stall_cnt = 0;
        gaps_seen = 0;
        have_last = 1'b0;
        gap_chk   = 1'b1;
        for (int f = 0; f < 3; f++) begin
            push_exp(6089, 1'b0);
            send_frame(1, 1, 0);
        end
        drain("drain_b2b");
        gap_chk = 1'b0;
        check("b2b_pre_ready_stalls", longint'(stall_cnt), 0);
        check("b2b_gaps_seen", longint'(gaps_seen), 2);

        // sink stalled through two frames; second frame kernel 2: 12168 + 5
        i_post_ready = 1'b0;
        push_exp(6089, 1'b0);
        send_frame(1, 1, 0);
        push_exp(12173, 1'b0);
        send_frame(1, 2, 0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("stall_pre_ready", longint'(o_pre_ready), 0);
        check("stall_post_valid", longint'(o_post_valid), 1);
        check("stall_res_held", longint'(o_res[0]), 6089);
        check("stall_wt_addr", longint'(o_wt_addr), N_TILES - 1);
        @(posedge i_clk);
        #1;
        i_post_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("release_post_valid", longint'(o_post_valid), 1);
        check("release_res_next", longint'(o_res[0]), 12173);
        drain("drain_stall");

        // reset partway through a frame while a result is held
        i_post_ready = 1'b0;
        send_frame(1, 1, 0);
        repeat (3) @(posedge i_clk);
        #1;
        check("pre_rst_post_valid", longint'(o_post_valid), 1);
        check("pre_rst_res", longint'(o_res[0]), 6089);
        for (int b = 0; b < 12; b++) send_beat(1, 1, 0);
        i_pre_valid = 1'b0;
        @(posedge i_clk);
        #1;
        check("pre_rst_wt_addr", longint'(o_wt_addr), 12);
        #2;
        i_rst = 1'b1;
        #1;
        check("mid_rst_post_valid", longint'(o_post_valid), 0);
        check("mid_rst_res0", longint'(o_res[0]), 0);
        check("mid_rst_res_last", longint'(o_res[N_CLS-1]), 0);
        check("mid_rst_wt_addr", longint'(o_wt_addr), 0);
        check("mid_rst_pre_ready", longint'(o_pre_ready), 1);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_post_ready = 1'b1;
        push_exp(6089, 1'b0);
        send_frame(1, 1, 0);
        drain("drain_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_fc_pipe.md
CONV_FC_PIPE -- requirements
Module: conv_fc_pipe

Interface
REQ-001 SHALL have parameters: IN_W, default 8, signed operand width; N_TAPS, default 9, kernel taps per conv output; N_POS, default 26, conv outputs per beat; N_TILES, default 26, beats per frame; N_CLS, default 10, FC classes; ACC_W, default 32, FC accumulator width.
REQ-002 SHALL expose: i_clk  in  1  clock; i_rst  in  1  asynchronous active-high reset.
REQ-003 SHALL expose: i_pre_valid  in  1  beat valid; o_pre_ready  out  1  beat accepted.
REQ-004 SHALL expose: i_patch  in  [N_POS][N_TAPS] x IN_W  signed input patches.
REQ-005 SHALL expose: i_conv_kernel  in  [N_TAPS] x IN_W  signed kernel; i_conv_bias  in  IN_W  signed conv bias.
REQ-006 SHALL expose: o_wt_addr  out  clog2(N_TILES)  tile index of beat in stage 2; i_fc_weight  in  [N_CLS][N_POS] x IN_W  signed weights for o_wt_addr, sampled the same cycle.
REQ-007 SHALL expose: i_fc_bias  in  [N_CLS] x IN_W  signed FC bias.
REQ-008 SHALL expose: o_post_valid  out  1; i_post_ready  in  1; o_res  out  [N_CLS] x ACC_W  signed class scores.

Function
REQ-009 Stage 1 SHALL register conv[p] = i_conv_bias + sum_t i_patch[p][t]*i_conv_kernel[t] on pre-fire, at full precision CW = 2*IN_W+clog2(N_TAPS)+1, with conv_vld set; latency 1 cycle.
REQ-010 o_pre_ready SHALL equal !conv_vld || s2_take, with no combinational path from i_pre_valid.
REQ-011 Stage 2 SHALL take a beat (s2_take) when conv_vld and not (tile == N_TILES-1 and o_post_valid and !i_post_ready).
REQ-012 On s2_take, acc[k] SHALL be loaded with sext(i_fc_bias[k]) + dot(conv, i_fc_weight[k]) when tile == 0, else acc[k] + dot(...); arithmetic wraps modulo 2^ACC_W.
REQ-013 Tile counter SHALL increment on s2_take and wrap N_TILES-1 -> 0; o_wt_addr SHALL equal the tile counter.
REQ-014 On s2_take at tile N_TILES-1, o_res SHALL load the final sums and o_post_valid SHALL be set; the accumulator is free for the next frame the following cycle.
REQ-015 o_post_valid SHALL stay high with o_res stable until post-fire; it clears on post-fire unless a new final tile is taken the same cycle, in which case it stays high with new o_res (no bubble).
REQ-016 Throughput with i_post_ready held high SHALL be one beat per cycle; one o_post_valid per N_TILES beats.

Reset
REQ-017 Asynchronous i_rst SHALL clear conv_vld, tile counter, o_post_valid, acc and o_res to 0; o_pre_ready is 1 after reset.
REQ-018 Reset mid-frame SHALL discard the partial frame; the next accepted beat is tile 0.

Configuration
REQ-019 With CONV_FC_RELU_EN defined, stage-1 conv results SHALL be clamped to max(0, conv) before registering; without it, signed results pass unchanged.

Structure
REQ-020 Package conv_fc_pkg SHALL hold default parameter constants, CW/product-width functions and the tile-index type.
REQ-021 One sub-module fc_mac_row (one FC class: dot product, bias-init, accumulate) SHALL be instantiated N_CLS times.

Verification
REQ-022 Defaults; patch=1, kernel=1, conv bias 0, fc weight=1, fc bias 5, 26 beats -> o_res[k] = 9*676+5 = 6089 for all k.
REQ-023 kernel=-1, other values as in REQ-022 -> o_res = -6084+5 = -6079 without CONV_FC_RELU_EN; o_res = 5 with it.
REQ-024 i_post_ready=0 through two frames -> second frame stalls at tile 25, o_pre_ready low, first o_res unchanged; raising i_post_ready -> second result next cycle.
REQ-025 Back-to-back frames, i_post_ready=1 -> o_post_valid exactly once every 26 cycles, o_pre_ready never low.
REQ-026 Assert i_rst at tile 12 -> outputs 0 immediately; next frame of 26 beats -> 6089, no residue.
